// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken-branch and memory-wait handling.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned RD_W     = 3,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [RD_W-1:0] IDRs1,
  input  logic [RD_W-1:0] IDRs2,
  input  logic            IDUsesRs1,
  input  logic            IDUsesRs2,
  input  logic            EXMemRead,
  input  logic [RD_W-1:0] EXRd,
  input  logic            BranchTaken,
  input  logic            MemReq,
  input  logic            MemAck,
  output logic            PCWrite,
  output logic            IFIDWrite,
  output logic            IDEXWrite,
  output logic            EXMEMWrite,
  output logic            MEMWBWrite,
  output logic            IFIDFlush,
  output logic            IDEXFlush,
  output logic            MEMWBBubble,
  output logic            MemBusy,
  output logic            Fault,
  output logic [15:0]     StallCycles
);

  localparam int unsigned WAIT_W    = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              load_use;
  logic              mem_stall;

  assign load_use = EXMemRead & ((IDUsesRs1 & (IDRs1 == EXRd)) |
                                 (IDUsesRs2 & (IDRs2 == EXRd)));
  assign mem_stall = ((state_q == RUN) & MemReq & ~MemAck) |
                     ((state_q == MEM_WAIT) & ~MemAck);

  // Next state and watchdog count
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (MemReq && !MemAck) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (MemAck) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
    if (Reset) begin
      state_d = RUN;
      wait_d  = '0;
    end
  end

  // Pipeline-register controls, highest-priority condition wins
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    MEMWBWrite  = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MEMWBBubble = 1'b0;
    MemBusy     = (state_q == MEM_WAIT);
    Fault       = 1'b0;
    if (Reset || state_q == FAULT) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
      MemBusy    = 1'b0;
      Fault      = ~Reset;
    end else if (mem_stall) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (load_use) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    wait_q  <= wait_d;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles with the PC held
  always_comb begin
    stall_d = stall_q;
    if (Reset) stall_d = '0;
    else if (!PCWrite && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge CLK) stall_q <= stall_d;

  assign StallCycles = stall_q;
`else
  assign StallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl plus hand-written watchdog sequences.
module tb_pipe_hazard_ctrl;

  // exp bit order: PCWrite IFIDWrite IDEXWrite EXMEMWrite MEMWBWrite IFIDFlush IDEXFlush MEMWBBubble MemBusy Fault
  localparam logic [9:0] RST = 10'b00000_000_00;
  localparam logic [9:0] DEF = 10'b11111_000_00;
  localparam logic [9:0] LU  = 10'b00111_010_00;
  localparam logic [9:0] BR  = 10'b11111_110_00;
  localparam logic [9:0] MS  = 10'b00001_001_00;
  localparam logic [9:0] MW  = 10'b00001_001_10;
  localparam logic [9:0] FLT = 10'b00000_000_01;
  localparam logic [9:0] ALL = 10'h3FF;
  localparam logic [9:0] ACK = 10'h3FD;

  typedef struct {
    string      name;
    logic       rst, br, req, ack, mr, u1, u2;
    logic [2:0] rd, rs1, rs2;
    logic [9:0] exp, mask;
  } vec_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  IDRs1 = '0, IDRs2 = '0, EXRd = '0;
  logic        IDUsesRs1 = 0, IDUsesRs2 = 0, EXMemRead = 0, BranchTaken = 0;
  logic        MemReq = 0, MemAck = 0;
  logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
  logic        IFIDFlush, IDEXFlush, MEMWBBubble, MemBusy, Fault;
  logic [15:0] StallCycles;

  int passed = 0;
  int total  = 0;
  int exp_stall = 0;
  vec_t tbl[$];

  pipe_hazard_ctrl dut (
    .CLK(CLK), .Reset(Reset), .IDRs1(IDRs1), .IDRs2(IDRs2),
    .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2), .EXMemRead(EXMemRead),
    .EXRd(EXRd), .BranchTaken(BranchTaken), .MemReq(MemReq), .MemAck(MemAck),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .MEMWBBubble(MEMWBBubble), .MemBusy(MemBusy),
    .Fault(Fault), .StallCycles(StallCycles)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input string name, input logic rst, input logic br,
                              input logic req, input logic ack, input logic mr,
                              input logic [2:0] rd, input logic [2:0] rs1, input logic u1,
                              input logic [2:0] rs2, input logic u2,
                              input logic [9:0] exp, input logic [9:0] mask);
    vec_t v;
    v.name = name; v.rst = rst; v.br = br; v.req = req; v.ack = ack; v.mr = mr;
    v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exp = exp; v.mask = mask;
    return v;
  endfunction

  // One clock cycle: drive after the edge, check mid-cycle, update the counter model
  task automatic apply(input vec_t v);
    logic [9:0]  act;
    logic [15:0] exp_sc;
    @(posedge CLK);
    #1;
    Reset = v.rst; BranchTaken = v.br; MemReq = v.req; MemAck = v.ack;
    EXMemRead = v.mr; EXRd = v.rd; IDRs1 = v.rs1; IDUsesRs1 = v.u1;
    IDRs2 = v.rs2; IDUsesRs2 = v.u2;
    #3;
    act = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
           IFIDFlush, IDEXFlush, MEMWBBubble, MemBusy, Fault};
    total++;
    if ((act & v.mask) === (v.exp & v.mask)) passed++;
    else $display("FAIL %s: outputs got %b want %b (mask %b)", v.name, act, v.exp, v.mask);
`ifdef PIPE_STALL_CNT_EN
    exp_sc = 16'(exp_stall);
`else
    exp_sc = 16'h0000;
`endif
    total++;
    if (StallCycles === exp_sc) passed++;
    else $display("FAIL %s.StallCycles: got %0d want %0d", v.name, StallCycles, exp_sc);
    if (v.rst) exp_stall = 0;
    else if (!v.exp[9] && exp_stall < 65535) exp_stall++;
  endtask

  initial begin
    //                 name          rst br req ack mr rd rs1 u1 rs2 u2 exp mask
    tbl.push_back(mk("reset0",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, ALL));
    tbl.push_back(mk("reset_req",    1, 1, 1, 0, 1, 3, 3, 1, 0, 0, RST, ALL));
    tbl.push_back(mk("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));
    tbl.push_back(mk("lu_rs1",       0, 0, 0, 0, 1, 3, 3, 1, 0, 0, LU,  ALL));
    tbl.push_back(mk("lu_after",     0, 0, 0, 0, 0, 3, 3, 1, 0, 0, DEF, ALL));
    tbl.push_back(mk("lu_rs2",       0, 0, 0, 0, 1, 5, 5, 0, 5, 1, LU,  ALL));
    tbl.push_back(mk("no_uses",      0, 0, 0, 0, 1, 5, 5, 0, 5, 0, DEF, ALL));
    tbl.push_back(mk("reg_differ",   0, 0, 0, 0, 1, 2, 3, 1, 4, 1, DEF, ALL));
    tbl.push_back(mk("lu_r0",        0, 0, 0, 0, 1, 0, 0, 1, 0, 0, LU,  ALL));
    tbl.push_back(mk("no_load",      0, 0, 0, 0, 0, 3, 3, 1, 3, 1, DEF, ALL));
    tbl.push_back(mk("br_over_lu",   0, 1, 0, 0, 1, 3, 3, 1, 0, 0, BR,  ALL));
    tbl.push_back(mk("br_only",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, BR,  ALL));
    tbl.push_back(mk("zero_wait",    0, 0, 1, 1, 0, 0, 0, 0, 0, 0, DEF, ALL));
    tbl.push_back(mk("zero_wait_nx", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));
    tbl.push_back(mk("mw_c1",        0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MS,  ALL));
    tbl.push_back(mk("mw_c2",        0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MW,  ALL));
    tbl.push_back(mk("mw_c3",        0, 1, 1, 0, 1, 3, 3, 1, 0, 0, MW,  ALL));
    tbl.push_back(mk("mw_ack",       0, 0, 1, 1, 0, 0, 0, 0, 0, 0, DEF, ACK));
    tbl.push_back(mk("mw_after",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));
    tbl.push_back(mk("mw2_c1",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MS,  ALL));
    tbl.push_back(mk("mw2_ack_lu",   0, 0, 1, 1, 1, 6, 1, 0, 6, 1, LU,  ACK));
    tbl.push_back(mk("mw2_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));
    tbl.push_back(mk("rst_mw_c1",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MS,  ALL));
    tbl.push_back(mk("rst_mw_c2",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MW,  ALL));
    tbl.push_back(mk("rst_in_mw",    1, 0, 1, 0, 0, 0, 0, 0, 0, 0, RST, ALL));
    tbl.push_back(mk("rst_mw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));
    foreach (tbl[i]) apply(tbl[i]);

    // Ack arriving on the last allowed wait cycle must still release
    apply(mk("late_c0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MS, ALL));
    for (int i = 0; i < 14; i++) apply(mk("late_wait", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MW, ALL));
    apply(mk("late_ack", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, DEF, ACK));
    apply(mk("late_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));

    // Watchdog: one RUN stall, 15 wait cycles, then sticky fault
    apply(mk("wd_c0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MS, ALL));
    for (int i = 0; i < 15; i++) apply(mk("wd_wait", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MW, ALL));
    apply(mk("wd_fault", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, FLT, ALL));
    apply(mk("wd_hold_ack", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, FLT, ALL));
    apply(mk("wd_hold_br", 0, 1, 0, 0, 1, 3, 3, 1, 0, 0, FLT, ALL));
    apply(mk("wd_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, ALL));
    apply(mk("wd_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL));
    apply(mk("wd_after_lu", 0, 0, 0, 0, 1, 7, 2, 0, 7, 1, LU, ALL));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
